// File: rtl/rd_tracker_pkg.sv
// Shared running-disparity definitions for rd_tracker: RD encodings, 10b symbol
// width, legal code-group weights and the popcount helper.
package rd_pkg;

    typedef enum logic {
        RD_MINUS = 1'b0,
        RD_PLUS  = 1'b1
    } rd_state_e;

    localparam int SYM_W = 10;

    localparam logic [3:0] WEIGHT_NEG = 4'd4;
    localparam logic [3:0] WEIGHT_NEU = 4'd5;
    localparam logic [3:0] WEIGHT_POS = 4'd6;

    function automatic logic [3:0] popcount(input logic [SYM_W-1:0] sym);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < SYM_W; i++) begin
            n = n + {3'b000, sym[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rd_tracker_if.sv
// Beat-level bus between a code-group source and rd_tracker.
// The o_err_cnt signal exists only when RD_ERR_CNT_EN is defined.
interface rd_tracker_if
    import rd_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int SYMS      = 2,
    parameter int ERR_CNT_W = 16
);

    logic                        i_valid;
    logic [LANES*SYMS*SYM_W-1:0] i_data;
    logic [LANES-1:0]            i_lane_init;
    logic                        o_valid;
    logic [LANES*SYMS-1:0]       o_rd_in;
    logic [LANES-1:0]            o_rd;
    logic [LANES*SYMS-1:0]       o_disp_err;
`ifdef RD_ERR_CNT_EN
    logic [LANES*ERR_CNT_W-1:0]  o_err_cnt;
`endif

    if (LANES < 1 || SYMS < 1 || ERR_CNT_W < 1) begin : g_bad_cfg
        $error("rd_tracker_if: LANES, SYMS and ERR_CNT_W must all be at least 1");
    end

    modport master (
        output i_valid, i_data, i_lane_init,
`ifdef RD_ERR_CNT_EN
        input  o_err_cnt,
`endif
        input  o_valid, o_rd_in, o_rd, o_disp_err
    );

    modport slave (
        input  i_valid, i_data, i_lane_init,
`ifdef RD_ERR_CNT_EN
        output o_err_cnt,
`endif
        output o_valid, o_rd_in, o_rd, o_disp_err
    );

endinterface

// File: rtl/rd_tracker_sym_step.sv
// Single 10b symbol running-disparity step: given the entering RD, produce the
// exit RD and flag illegal weights or disparity that contradicts the entering RD.
module rd_sym_step
    import rd_pkg::*;
(
    input  logic             rd_in,
    input  logic [SYM_W-1:0] sym,
    output logic             rd_out,
    output logic             err
);

    logic [3:0] weight;

    // Unbalanced symbols force RD to their own polarity even when flagged, so a
    // single bad symbol does not cascade into errors on the symbols after it.
    always_comb begin
        weight = popcount(sym);
        rd_out = rd_in;
        err    = 1'b0;
        case (weight)
            WEIGHT_NEU: begin
                rd_out = rd_in;
            end
            WEIGHT_POS: begin
                err    = (rd_in == RD_PLUS);
                rd_out = RD_PLUS;
            end
            WEIGHT_NEG: begin
                err    = (rd_in == RD_MINUS);
                rd_out = RD_MINUS;
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rd_tracker.sv
// Multi-lane, multi-symbol running-disparity tracker with one clock of latency.
// Define RD_ERR_CNT_EN to add saturating per-lane error counters on o_err_cnt.
module rd_tracker
    import rd_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int SYMS      = 2,
    parameter int ERR_CNT_W = 16
)
(
    input logic          clk,
    input logic          rst_n,
    rd_tracker_if.slave  bus
);

    localparam int NSYM = LANES * SYMS;

    rd_state_e [LANES-1:0]      state_q;
    rd_state_e [LANES-1:0]      state_d;
    logic [LANES-1:0]           rdEntry;
    logic [LANES-1:0][SYMS-1:0] symRdIn;
    logic [LANES-1:0][SYMS-1:0] symRdOut;
    logic [LANES-1:0][SYMS-1:0] symErr;
    logic                       valid_q;
    logic [NSYM-1:0]            rdIn_q;
    logic [NSYM-1:0]            dispErr_q;

    if (LANES < 1 || SYMS < 1 || ERR_CNT_W < 1) begin : g_bad_cfg
        $error("rd_tracker: LANES, SYMS and ERR_CNT_W must all be at least 1");
    end

    always_comb begin
        rdEntry = '0;
        for (int l = 0; l < LANES; l++) begin
            rdEntry[l] = bus.i_lane_init[l] ? RD_MINUS : state_q[l];
        end
    end

    // Each lane is a chain of symbol steps, symbol 0 first in time.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar s = 0; s < SYMS; s++) begin : g_sym
            if (s == 0) begin : g_first
                assign symRdIn[l][s] = rdEntry[l];
            end else begin : g_next
                assign symRdIn[l][s] = symRdOut[l][s-1];
            end

            rd_sym_step u_step (
                .rd_in  (symRdIn[l][s]),
                .sym    (bus.i_data[(l*SYMS+s)*SYM_W +: SYM_W]),
                .rd_out (symRdOut[l][s]),
                .err    (symErr[l][s])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                state_q[l] <= RD_MINUS;
            end
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        for (int l = 0; l < LANES; l++) begin
            if (bus.i_valid) begin
                state_d[l] = rd_state_e'(symRdOut[l][SYMS-1]);
            end else if (bus.i_lane_init[l]) begin
                state_d[l] = RD_MINUS;
            end
        end
    end

    // Per-symbol outputs keep their last beat while idle; consumers qualify with o_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rdIn_q    <= '0;
            dispErr_q <= '0;
        end else begin
            valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                rdIn_q    <= symRdIn;
                dispErr_q <= symErr;
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_rd_in    = rdIn_q;
    assign bus.o_rd       = state_q;
    assign bus.o_disp_err = dispErr_q;

`ifdef RD_ERR_CNT_EN
    localparam int SUM_W = ERR_CNT_W + 1;

    logic [LANES-1:0][ERR_CNT_W-1:0] cnt_q;
    logic [LANES-1:0][ERR_CNT_W-1:0] cnt_d;

    // A lane init with a valid beat restarts the count at that beat's errors.
    always_comb begin
        logic [ERR_CNT_W-1:0] base;
        logic [SUM_W-1:0]     sum;
        int                   nErr;
        cnt_d = cnt_q;
        base  = '0;
        sum   = '0;
        nErr  = 0;
        for (int l = 0; l < LANES; l++) begin
            nErr = 0;
            for (int s = 0; s < SYMS; s++) begin
                nErr = nErr + int'(symErr[l][s]);
            end
            base = bus.i_lane_init[l] ? '0 : cnt_q[l];
            sum  = {1'b0, base} + SUM_W'(nErr);
            if (bus.i_valid) begin
                cnt_d[l] = sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
            end else if (bus.i_lane_init[l]) begin
                cnt_d[l] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_err_cnt = cnt_q;
`endif

endmodule
